// File: rtl/serdes_tx_scheduler_if.sv
// serdes_tx_scheduler_if: bus between the two frame requesters, the serializer
// and the tx scheduler.
//   i_Ser_Ready                serializer takes a symbol this cycle
//   i_ReqN_Valid/Data/Last     requester N byte stream (N = 0, 1)
//   o_ReqN_Ready               requester N byte consumed this cycle
//   o_Data/o_K/o_S_en          registered symbol to the 8b/10b encoder
//   o_Grant/o_Busy             current frame owner / frame in progress
// master = requester/serializer side, slave = scheduler.
interface serdes_tx_scheduler_if;
  logic       i_Ser_Ready;
  logic       i_Req0_Valid;
  logic [7:0] i_Req0_Data;
  logic       i_Req0_Last;
  logic       o_Req0_Ready;
  logic       i_Req1_Valid;
  logic [7:0] i_Req1_Data;
  logic       i_Req1_Last;
  logic       o_Req1_Ready;
  logic [7:0] o_Data;
  logic       o_K;
  logic       o_S_en;
  logic [1:0] o_Grant;
  logic       o_Busy;

  modport master (
    output i_Ser_Ready,
    output i_Req0_Valid, i_Req0_Data, i_Req0_Last,
    output i_Req1_Valid, i_Req1_Data, i_Req1_Last,
    input  o_Req0_Ready, o_Req1_Ready,
    input  o_Data, o_K, o_S_en, o_Grant, o_Busy
  );

  modport slave (
    input  i_Ser_Ready,
    input  i_Req0_Valid, i_Req0_Data, i_Req0_Last,
    input  i_Req1_Valid, i_Req1_Data, i_Req1_Last,
    output o_Req0_Ready, o_Req1_Ready,
    output o_Data, o_K, o_S_en, o_Grant, o_Busy
  );
endinterface

// File: rtl/serdes_tx_scheduler.sv
// serdes_tx_scheduler: picks one symbol per i_Clk for the 8b/10b encoder.
// Whole frames from two requesters are arbitrated round-robin, wrapped in
// SOF_K/EOF_K, idle time is filled with COMMA_K, and a comma is forced once
// ALIGN_PERIOD non-comma symbols have gone out back to back.
// Ports:
//   i_Clk  symbol clock
//   i_Rst  synchronous active-high reset
//   bus    serdes_tx_scheduler_if.slave (requesters, serializer, status)
module serdes_tx_scheduler #(
  parameter int         ALIGN_PERIOD = 16,
  parameter logic [7:0] COMMA_K      = 8'hBC,
  parameter logic [7:0] SOF_K        = 8'hFB,
  parameter logic [7:0] EOF_K        = 8'hFD
) (
  input logic                  i_Clk,
  input logic                  i_Rst,
  serdes_tx_scheduler_if.slave bus
);
  localparam logic [7:0] ALIGN_MAX = 8'(ALIGN_PERIOD);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_EOF} state_t;

  state_t          state;
  logic            rr_ptr;
  logic [7:0]      align_cnt;
  logic [1:0]      grant;
  logic [7:0]      data_q;
  logic            k_q;
  logic            s_en_q;

  logic [1:0]      req_vld;
  logic [1:0]      req_last;
  logic [1:0][7:0] req_data;
  logic            emit;
  logic            force_comma;
  logic            own_idx;
  logic            own_vld;
  logic            win_idx;
  logic [1:0]      rdy;
  logic [7:0]      sym_data;
  logic            sym_k;
  logic            sym_comma;

  assign req_vld  = {bus.i_Req1_Valid, bus.i_Req0_Valid};
  assign req_last = {bus.i_Req1_Last,  bus.i_Req0_Last};
  assign req_data = {bus.i_Req1_Data,  bus.i_Req0_Data};

  assign emit        = bus.i_Ser_Ready;
  assign force_comma = (align_cnt == ALIGN_MAX);
  // grant is one-hot while a frame is open, so bit 1 is the owner index
  assign own_idx     = grant[1];
  assign own_vld     = req_vld[own_idx];
  // both valid -> rr_ptr decides; otherwise whichever one is valid
  assign win_idx     = (&req_vld) ? rr_ptr : req_vld[1];

  // a byte is only taken when it is actually the symbol going out
  assign rdy = (state == S_DATA && emit && !force_comma) ? grant : 2'b00;
  assign bus.o_Req0_Ready = rdy[0];
  assign bus.o_Req1_Ready = rdy[1];

  assign bus.o_Data  = data_q;
  assign bus.o_K     = k_q;
  assign bus.o_S_en  = s_en_q;
  assign bus.o_Grant = grant;
  assign bus.o_Busy  = (state != S_IDLE);

  // symbol for this cycle; comma is the fallback (forced, idle, underrun fill)
  always_comb begin
    sym_data  = COMMA_K;
    sym_k     = 1'b1;
    sym_comma = 1'b1;
    if (!force_comma) begin
      case (state)
        S_IDLE: if (|req_vld) begin
          sym_data  = SOF_K;
          sym_comma = 1'b0;
        end
        S_DATA: if (own_vld) begin
          // a data byte of 8'hBC goes out with K=0 and is not a comma
          sym_data  = req_data[own_idx];
          sym_k     = 1'b0;
          sym_comma = 1'b0;
        end
        S_EOF: begin
          sym_data  = EOF_K;
          sym_comma = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state     <= S_IDLE;
      rr_ptr    <= 1'b0;
      align_cnt <= '0;
      grant     <= 2'b00;
      data_q    <= 8'h00;
      k_q       <= 1'b0;
      s_en_q    <= 1'b0;
    end else begin
      s_en_q <= emit;
      if (emit) begin
        data_q <= sym_data;
        k_q    <= sym_k;
        if (sym_comma)
          align_cnt <= '0;
        else if (align_cnt != ALIGN_MAX)
          align_cnt <= align_cnt + 8'd1;
        // a forced comma freezes the frame state for this symbol
        if (!force_comma) begin
          case (state)
            S_IDLE: if (|req_vld) begin
              grant <= win_idx ? 2'b10 : 2'b01;
              state <= S_DATA;
            end
            S_DATA: if (own_vld && req_last[own_idx]) state <= S_EOF;
            S_EOF: begin
              rr_ptr <= ~own_idx;
              grant  <= 2'b00;
              state  <= S_IDLE;
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_serdes_tx_scheduler.sv
module tb_serdes_tx_scheduler;
  logic gclk = 1'b0;
  logic rst  = 1'b1;
  always #5 gclk = ~gclk;

  serdes_tx_scheduler_if bus();
  serdes_tx_scheduler_if bus4();

  serdes_tx_scheduler #(.ALIGN_PERIOD(16)) dut (.i_Clk(gclk), .i_Rst(rst), .bus(bus));
  serdes_tx_scheduler #(.ALIGN_PERIOD(4))  dut4 (.i_Clk(gclk), .i_Rst(rst), .bus(bus4));

  int total = 0;
  int bad   = 0;

  // requester queues: {last, data}
  logic [8:0]  q0[$], q1[$], q4[$];
  // expected bytes per owner for the random-phase stream checker
  logic [8:0]  exp0[$], exp1[$];
  // captured symbols: {grant, K, data}
  logic [10:0] cap[$], cap4[$];

  logic xf0 = 0, xf1 = 0, xf4 = 0;
  int   n_xf0 = 0, rdy_cnt0 = 0, rdy_cnt4 = 0;
  logic prev16 = 0, prev4 = 0;
  logic lag_on = 0, stream_on = 0;

  int   p_st  = 0;
  logic p_own = 0;
  int   run   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #2;
  endtask

  // stream-level check: frames well formed, bytes in order per owner,
  // comma spacing bounded, grant consistent with the frame owner
  task automatic parse(input logic [10:0] s);
    logic [1:0] g;
    logic       k;
    logic [7:0] d;
    logic [8:0] e;
    logic       is_comma;
    g = s[10:9];
    k = s[8];
    d = s[7:0];
    is_comma = k && (d == 8'hBC);
    if (is_comma) run = 0;
    else run++;
    chk("align_run", run <= 16, 1);
    case (p_st)
      0: if (!is_comma) begin
        chk("idle_sym", s[8:0], 9'h1FB);
        chk("sof_grant", (g == 2'b01) || (g == 2'b10), 1);
        p_own = g[1];
        p_st  = 1;
      end
      1: if (!is_comma) begin
        chk("frame_k", k, 0);
        chk("frame_grant", g, p_own ? 2'b10 : 2'b01);
        if (p_own) begin
          chk("exp1_left", exp1.size() > 0, 1);
          e = (exp1.size() > 0) ? exp1.pop_front() : 9'h000;
        end else begin
          chk("exp0_left", exp0.size() > 0, 1);
          e = (exp0.size() > 0) ? exp0.pop_front() : 9'h000;
        end
        chk("frame_data", d, e[7:0]);
        if (e[8]) p_st = 2;
      end
      default: if (!is_comma) begin
        chk("eof_sym", s[8:0], 9'h1FD);
        chk("eof_grant", g, 2'b00);
        p_st = 0;
      end
    endcase
  endtask

  // requester driver + symbol monitor
  initial begin
    bus.i_Req0_Valid  = 0; bus.i_Req0_Data  = 0; bus.i_Req0_Last  = 0;
    bus.i_Req1_Valid  = 0; bus.i_Req1_Data  = 0; bus.i_Req1_Last  = 0;
    bus4.i_Req0_Valid = 0; bus4.i_Req0_Data = 0; bus4.i_Req0_Last = 0;
    bus4.i_Req1_Valid = 0; bus4.i_Req1_Data = 0; bus4.i_Req1_Last = 0;
    forever begin
      @(posedge gclk);
      #1;
      if (xf0 && q0.size() > 0) begin void'(q0.pop_front()); n_xf0++; end
      if (xf1 && q1.size() > 0) void'(q1.pop_front());
      if (xf4 && q4.size() > 0) void'(q4.pop_front());
      bus.i_Req0_Valid  = (q0.size() > 0);
      bus.i_Req0_Data   = (q0.size() > 0) ? q0[0][7:0] : 8'($urandom);
      bus.i_Req0_Last   = (q0.size() > 0) ? q0[0][8]   : 1'($urandom);
      bus.i_Req1_Valid  = (q1.size() > 0);
      bus.i_Req1_Data   = (q1.size() > 0) ? q1[0][7:0] : 8'($urandom);
      bus.i_Req1_Last   = (q1.size() > 0) ? q1[0][8]   : 1'($urandom);
      bus4.i_Req1_Valid = (q4.size() > 0);
      bus4.i_Req1_Data  = (q4.size() > 0) ? q4[0][7:0] : 8'($urandom);
      bus4.i_Req1_Last  = (q4.size() > 0) ? q4[0][8]   : 1'($urandom);
      @(negedge gclk);
      xf0 = bus.i_Req0_Valid  && bus.o_Req0_Ready  && !rst;
      xf1 = bus.i_Req1_Valid  && bus.o_Req1_Ready  && !rst;
      xf4 = bus4.i_Req1_Valid && bus4.o_Req1_Ready && !rst;
      if (bus.o_Req0_Ready)  rdy_cnt0++;
      if (bus4.o_Req1_Ready) rdy_cnt4++;
      if (lag_on) begin
        chk("s_en_lag16", bus.o_S_en,  prev16);
        chk("s_en_lag4",  bus4.o_S_en, prev4);
      end
      prev16 = bus.i_Ser_Ready  && !rst;
      prev4  = bus4.i_Ser_Ready && !rst;
      if (bus.o_S_en) begin
        cap.push_back({bus.o_Grant, bus.o_K, bus.o_Data});
        if (stream_on) parse({bus.o_Grant, bus.o_K, bus.o_Data});
      end
      if (bus4.o_S_en) cap4.push_back({bus4.o_Grant, bus4.o_K, bus4.o_Data});
    end
  end

  // find the first SOF in the capture and compare the stream from there
  task automatic cmp_seq(input string tag, input logic [10:0] c[$], input logic [8:0] e[$]);
    int st;
    st = -1;
    foreach (c[i]) if (st < 0 && c[i][8:0] == 9'h1FB) st = i;
    if (st < 0) st = c.size();
    chk({tag, "_len"}, (c.size() - st) >= e.size(), 1);
    for (int i = 0; i < e.size(); i++)
      if (st + i < c.size()) chk($sformatf("%s_%0d", tag, i), c[st+i][8:0], e[i]);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_data"},  bus.o_Data,       8'h00);
    chk({tag, "_k"},     bus.o_K,          0);
    chk({tag, "_s_en"},  bus.o_S_en,       0);
    chk({tag, "_rdy0"},  bus.o_Req0_Ready, 0);
    chk({tag, "_rdy1"},  bus.o_Req1_Ready, 0);
    chk({tag, "_grant"}, bus.o_Grant,      2'b00);
    chk({tag, "_busy"},  bus.o_Busy,       0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [8:0] e[$];
    int         nsof;
    logic [1:0] own_exp[4];
    int         k;
    bus.i_Ser_Ready  = 1;
    bus4.i_Ser_Ready = 1;
    rst = 1;
    repeat (3) tick();
    check_reset_vals("reset");

    // idle commas
    rst = 0;
    cap.delete();
    k = 0;
    while (cap.size() < 10 && k < 50) begin tick(); k++; end
    chk("idle_cnt", cap.size() >= 10, 1);
    for (int i = 0; i < 10 && i < cap.size(); i++)
      chk($sformatf("idle_%0d", i), cap[i], {2'b00, 9'h1BC});
    chk("idle_busy", bus.o_Busy, 0);

    // single 3-byte frame from requester 0
    cap.delete();
    rdy_cnt0 = 0;
    q0.push_back(9'h011); q0.push_back(9'h022); q0.push_back(9'h133);
    repeat (12) tick();
    e = '{9'h1FB, 9'h011, 9'h022, 9'h033, 9'h1FD, 9'h1BC};
    cmp_seq("frame3", cap, e);
    chk("frame3_rdy_cycles", rdy_cnt0, 3);

    // both requesters, two frames each, round-robin from reset
    rst = 1;
    tick();
    cap.delete();
    q0.push_back(9'h0A1); q0.push_back(9'h1A2); q0.push_back(9'h0A1); q0.push_back(9'h1A2);
    q1.push_back(9'h0B1); q1.push_back(9'h1B2); q1.push_back(9'h0B1); q1.push_back(9'h1B2);
    tick();
    rst = 0;
    repeat (25) tick();
    e = '{9'h1FB, 9'h0A1, 9'h0A2, 9'h1FD, 9'h1FB, 9'h0B1, 9'h0B2, 9'h1FD,
          9'h1FB, 9'h0A1, 9'h0A2, 9'h1FD, 9'h1FB, 9'h0B1, 9'h0B2, 9'h1FD, 9'h1BC};
    cmp_seq("rr", cap, e);
    own_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    nsof = 0;
    foreach (cap[i]) if (cap[i][8:0] == 9'h1FB) begin
      if (nsof < 4) chk($sformatf("rr_owner_%0d", nsof), cap[i][10:9], own_exp[nsof]);
      nsof++;
    end
    chk("rr_nsof", nsof, 4);

    // ALIGN_PERIOD=4: comma forced inside the frame, requester held off
    cap4.delete();
    rdy_cnt4 = 0;
    for (int i = 1; i <= 6; i++) q4.push_back({(i == 6), 8'(i)});
    repeat (15) tick();
    e = '{9'h1FB, 9'h001, 9'h002, 9'h003, 9'h1BC, 9'h004, 9'h005, 9'h006, 9'h1FD, 9'h1BC};
    cmp_seq("align4", cap4, e);
    chk("align4_rdy_cycles", rdy_cnt4, 6);

    // serializer ready toggling mid-frame
    cap.delete();
    cap4.delete();
    lag_on = 1;
    q0.push_back(9'h0C1); q0.push_back(9'h0C2); q0.push_back(9'h1C3);
    q4.push_back(9'h0D1); q4.push_back(9'h0D2); q4.push_back(9'h1D3);
    for (int i = 0; i < 20; i++) begin
      bus.i_Ser_Ready  = (i % 2 == 0);
      bus4.i_Ser_Ready = (i % 2 == 0);
      tick();
    end
    bus.i_Ser_Ready  = 1;
    bus4.i_Ser_Ready = 1;
    repeat (4) tick();
    e = '{9'h1FB, 9'h0C1, 9'h0C2, 9'h0C3, 9'h1FD};
    cmp_seq("toggle16", cap, e);
    e = '{9'h1FB, 9'h0D1, 9'h0D2, 9'h0D3, 9'h1BC, 9'h1FD};
    cmp_seq("toggle4", cap4, e);

    // reset after byte 2 of a 5-byte frame
    lag_on = 0;
    n_xf0  = 0;
    for (int i = 1; i <= 5; i++) q0.push_back({(i == 5), 8'h50 + 8'(i)});
    k = 0;
    while (n_xf0 < 2 && k < 30) begin tick(); k++; end
    chk("midrst_bytes", n_xf0, 2);
    rst = 1;
    tick();
    check_reset_vals("midrst");
    q0.delete();
    tick();
    cap.delete();
    q0.push_back(9'h061); q0.push_back(9'h162);
    rst = 0;
    repeat (10) tick();
    chk("midrst_first", (cap.size() > 0) ? cap[0][8:0] : 9'h000, 9'h1BC);
    e = '{9'h1FB, 9'h061, 9'h062, 9'h1FD, 9'h1BC};
    cmp_seq("midrst_new", cap, e);

    // random frames, random serializer back-pressure
    p_st = 0; run = 0;
    stream_on = 1;
    lag_on    = 1;
    for (int c = 0; c < 400; c++) begin
      bus.i_Ser_Ready = ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0) begin
        automatic int r   = $urandom_range(1);
        automatic int len = $urandom_range(6, 1);
        for (int b = 0; b < len; b++) begin
          automatic logic [7:0] d = ($urandom_range(7) == 0) ? 8'hBC : 8'($urandom);
          automatic logic [8:0] w = {(b == len - 1), d};
          if (r == 1) begin q1.push_back(w); exp1.push_back(w); end
          else        begin q0.push_back(w); exp0.push_back(w); end
        end
      end
      tick();
    end
    bus.i_Ser_Ready = 1;
    k = 0;
    while ((q0.size() + q1.size() + exp0.size() + exp1.size() > 0 || bus.o_Busy) && k < 600) begin
      tick();
      k++;
    end
    repeat (3) tick();
    chk("drain_q",    q0.size() + q1.size(), 0);
    chk("drain_exp",  exp0.size() + exp1.size(), 0);
    chk("drain_busy", bus.o_Busy, 0);
    chk("drain_pst",  p_st, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
